// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: lets the elbeth_core instruction and data ports share one
// single-port word memory. Access order is round-robin. Byte addresses become
// word indices. Out-of-range and timed-out accesses are flagged back to the core.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   imem_en/addr/rw/out_data    instruction-port request (held until imem_ready)
//   imem_in_data/ready/error    instruction-port response (one-cycle ready pulse)
//   dmem_*                      same set for the data port
//   mem_en/addr/rw/out_data     memory request; held stable for a whole access
//   mem_in_data, mem_ready      memory response; ready may come in the first cycle
module elbeth_mem_arbiter #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_en,
  input  logic [31:0]          imem_addr,
  input  logic [3:0]           imem_rw,
  input  logic [31:0]          imem_out_data,
  output logic [31:0]          imem_in_data,
  output logic                 imem_ready,
  output logic                 imem_error,
  input  logic                 dmem_en,
  input  logic [31:0]          dmem_addr,
  input  logic [3:0]           dmem_rw,
  input  logic [31:0]          dmem_out_data,
  output logic [31:0]          dmem_in_data,
  output logic                 dmem_ready,
  output logic                 dmem_error,
  output logic                 mem_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_rw,
  output logic [31:0]          mem_out_data,
  input  logic [31:0]          mem_in_data,
  input  logic                 mem_ready
);

  localparam int unsigned CNT_W   = 8;
  localparam logic        GRANT_I = 1'b0;
  localparam logic        GRANT_D = 1'b1;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;

  logic              pick_d;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_rw;
  logic [31:0]       sel_wdata;
  logic              out_of_range;
  logic              timeout_hit;
  logic              resp_error;
  logic              busy_now;
  logic              busy_next;
  logic              any_req;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, range check and next-state decision
  always_comb begin
    state_next   = state;
    resp_error   = 1'b0;
    any_req      = imem_en || dmem_en;
    // D wins when alone, or on a tie when I was served last
    pick_d       = dmem_en && (!imem_en || (last_grant == GRANT_I));
    sel_addr     = pick_d ? dmem_addr     : imem_addr;
    sel_rw       = pick_d ? dmem_rw       : imem_rw;
    sel_wdata    = pick_d ? dmem_out_data : imem_out_data;
    out_of_range = (sel_addr >> (ADDR_BITS + 2)) != 32'd0;
    timeout_hit  = (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

    case (state)
      IDLE: begin
        if (any_req) begin
          if (out_of_range) begin
            state_next = pick_d ? RESP_D : RESP_I;
            resp_error = 1'b1;
          end else begin
            state_next = pick_d ? BUSY_D : BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // A ready on the final counted cycle still counts as success
        if (mem_ready) begin
          state_next = (state == BUSY_D) ? RESP_D : RESP_I;
        end else if (timeout_hit) begin
          state_next = (state == BUSY_D) ? RESP_D : RESP_I;
          resp_error = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_now  = (state == BUSY_I) || (state == BUSY_D);
    busy_next = (state_next == BUSY_I) || (state_next == BUSY_D);
  end

  // Registered responses, memory request and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= GRANT_I;
      cnt          <= '0;
      imem_ready   <= 1'b0;
      imem_error   <= 1'b0;
      imem_in_data <= '0;
      dmem_ready   <= 1'b0;
      dmem_error   <= 1'b0;
      dmem_in_data <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_rw       <= '0;
      mem_out_data <= '0;
    end else begin
      imem_ready <= (state_next == RESP_I);
      imem_error <= (state_next == RESP_I) && resp_error;
      dmem_ready <= (state_next == RESP_D);
      dmem_error <= (state_next == RESP_D) && resp_error;
      mem_en     <= busy_next;

      if ((state == IDLE) && any_req) begin
        last_grant <= pick_d ? GRANT_D : GRANT_I;
      end

      // Requester holds its bus stable through BUSY, so capturing at grant is enough
      if ((state == IDLE) && busy_next) begin
        mem_addr     <= sel_addr[ADDR_BITS+1:2];
        mem_rw       <= sel_rw;
        mem_out_data <= sel_wdata;
      end else if (!busy_next) begin
        mem_rw <= '0;
      end

      cnt <= busy_now ? (cnt + CNT_W'(1)) : '0;

      if ((state == BUSY_I) && (state_next == RESP_I)) begin
        imem_in_data <= mem_ready ? mem_in_data : 32'd0;
      end
      if ((state == BUSY_D) && (state_next == RESP_D)) begin
        dmem_in_data <= mem_ready ? mem_in_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Bench for elbeth_mem_arbiter: directed requests through per-port queues, a
// wait-state memory responder, and a cycle model of the arbitration rules that
// is compared against every DUT output on each falling edge.
module tb_elbeth_mem_arbiter;

  localparam int unsigned AB = 8;
  localparam int unsigned TO = 15;
  localparam longint unsigned SPAN = longint'(4) << AB;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rw;
    logic [31:0] wdata;
  } req_t;

  logic          clk;
  logic          rst;
  logic          imem_en, dmem_en;
  logic [31:0]   imem_addr, dmem_addr, imem_out_data, dmem_out_data;
  logic [3:0]    imem_rw, dmem_rw;
  logic [31:0]   imem_in_data, dmem_in_data;
  logic          imem_ready, imem_error, dmem_ready, dmem_error;
  logic          mem_en;
  logic [AB-1:0] mem_addr;
  logic [3:0]    mem_rw;
  logic [31:0]   mem_out_data;
  logic [31:0]   mem_in_data;
  logic          mem_ready;

  int n_vec = 0;
  int n_bad = 0;
  int cur   = 0;
  int ws    = 0;
  int bcnt  = 0;
  bit mem_inited = 0;
  req_t iq[$];
  req_t dq[$];
  logic [31:0] mem   [256];
  logic [31:0] m_mem [256];

  elbeth_mem_arbiter #(.ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rw(imem_rw),
    .imem_out_data(imem_out_data), .imem_in_data(imem_in_data),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rw(dmem_rw),
    .dmem_out_data(dmem_out_data), .dmem_in_data(dmem_in_data),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_out_data(mem_out_data), .mem_in_data(mem_in_data),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic req_t mk(logic [31:0] a, logic [3:0] rw, logic [31:0] wd);
    req_t r;
    r.addr = a; r.rw = rw; r.wdata = wd;
    return r;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory: ready after ws idle cycles of mem_en (ws<0 never answers)
  assign mem_ready   = mem_en && (ws >= 0) && (bcnt == ws);
  assign mem_in_data = mem[mem_addr];
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      mem_inited <= 1'b1;
    end else if (mem_en && mem_ready && (mem_rw != 4'd0)) begin
      mem[mem_addr] <= merge(mem[mem_addr], mem_out_data, mem_rw);
    end
    if (mem_en && !mem_ready) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  // Requesters: present queue head, retire it on the ready pulse
  initial begin
    imem_en = 0; imem_addr = 0; imem_rw = 0; imem_out_data = 0;
    dmem_en = 0; dmem_addr = 0; dmem_rw = 0; dmem_out_data = 0;
    forever begin
      @(posedge clk); #1;
      if (imem_ready && iq.size() > 0) void'(iq.pop_front());
      if (dmem_ready && dq.size() > 0) void'(dq.pop_front());
      if (iq.size() > 0) begin
        imem_en = 1; imem_addr = iq[0].addr; imem_rw = iq[0].rw; imem_out_data = iq[0].wdata;
      end else imem_en = 0;
      if (dq.size() > 0) begin
        dmem_en = 1; dmem_addr = dq[0].addr; dmem_rw = dq[0].rw; dmem_out_data = dq[0].wdata;
      end else dmem_en = 0;
    end
  end

  // Reference model: expected outputs for the coming cycle
  bit          m_valid = 0;
  int          m_phase = 0;   // 0 waiting for a request, 1 memory in flight, 2 answering
  int          m_owner = 0;   // 0 = I, 1 = D
  bit          m_last_d = 0;
  int          m_elapsed = 0;
  logic        e_irdy, e_ierr, e_drdy, e_derr, e_men;
  logic [31:0] e_idata, e_ddata, e_maddr, e_mwdata;
  logic [3:0]  e_mrw;

  function automatic void respond(int who, bit err, bit upd, logic [31:0] d);
    m_phase = 2; e_men = 0; e_mrw = 4'd0;
    if (who == 1) begin
      e_drdy = 1; e_derr = err; if (upd) e_ddata = d;
    end else begin
      e_irdy = 1; e_ierr = err; if (upd) e_idata = d;
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] a;
    logic [31:0] rd;
    if (m_valid) begin
      chk("imem_ready",   32'(imem_ready),   32'(e_irdy));
      chk("imem_error",   32'(imem_error),   32'(e_ierr));
      chk("imem_in_data", imem_in_data,      e_idata);
      chk("dmem_ready",   32'(dmem_ready),   32'(e_drdy));
      chk("dmem_error",   32'(dmem_error),   32'(e_derr));
      chk("dmem_in_data", dmem_in_data,      e_ddata);
      chk("mem_en",       32'(mem_en),       32'(e_men));
      chk("mem_rw",       32'(mem_rw),       32'(e_mrw));
      chk("mem_addr",     32'(mem_addr),     e_maddr);
      chk("mem_out_data", mem_out_data,      e_mwdata);
    end
    if (rst) begin
      m_valid = 1; m_phase = 0; m_last_d = 0;
      e_irdy = 0; e_ierr = 0; e_drdy = 0; e_derr = 0; e_men = 0;
      e_idata = 0; e_ddata = 0; e_maddr = 0; e_mwdata = 0; e_mrw = 0;
    end else if (m_valid) begin
      e_irdy = 0; e_ierr = 0; e_drdy = 0; e_derr = 0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (imem_en || dmem_en) begin
          if (dmem_en && imem_en) m_owner = m_last_d ? 0 : 1;
          else m_owner = dmem_en ? 1 : 0;
          m_last_d = (m_owner == 1);
          a = (m_owner == 1) ? dmem_addr : imem_addr;
          if (longint'(a) >= SPAN) begin
            respond(m_owner, 1, 0, 32'd0);
          end else begin
            m_phase = 1; m_elapsed = 0; e_men = 1;
            e_maddr  = a / 4;
            e_mrw    = (m_owner == 1) ? dmem_rw : imem_rw;
            e_mwdata = (m_owner == 1) ? dmem_out_data : imem_out_data;
          end
        end
      end else begin
        if (ws >= 0 && m_elapsed == ws) begin
          rd = m_mem[e_maddr];
          if (e_mrw != 4'd0) m_mem[e_maddr] = merge(rd, e_mwdata, e_mrw);
          respond(m_owner, 0, 1, rd);
        end else begin
          m_elapsed++;
          if (m_elapsed == TO) respond(m_owner, 1, 1, 32'd0);
        end
      end
    end
  end

  // Cycle 0 is the first cycle the queued request is visible to the arbiter
  task automatic start();
    @(posedge clk); #2; cur = 0;
  endtask

  task automatic goto(int k);
    if (k > cur) begin
      repeat (k - cur) @(posedge clk);
      cur = k;
      #6;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0) && n < 300) begin
      @(posedge clk); n++;
    end
    if (n >= 300) begin
      n_vec++; n_bad++;
      $display("FAIL idle_wait: queues i=%0d d=%0d still pending after %0d cycles", iq.size(), dq.size(), n);
      iq.delete(); dq.delete();
    end
    repeat (2) @(posedge clk);
    #6;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, want finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'hA500_0000 + 32'(i);
    rst = 1;
    repeat (3) @(posedge clk); #2;
    rst = 0;
    repeat (2) @(posedge clk); #6;

    // Single instruction read, zero-wait memory
    iq.push_back(mk(32'h10, 4'h0, 32'h0));
    start();
    goto(1); chk("t1_mem_en", 32'(mem_en), 32'd1); chk("t1_mem_addr", 32'(mem_addr), 32'h04);
    goto(2); chk("t1_irdy", 32'(imem_ready), 32'd1); chk("t1_idata", imem_in_data, 32'hA500_0004);
             chk("t1_drdy", 32'(dmem_ready), 32'd0);
    wait_idle();

    // Ties alternate, D first after an I service
    for (int r = 0; r < 2; r++) begin
      iq.push_back(mk(32'h20 + 32'(r*8), 4'h0, 32'h0));
      dq.push_back(mk(32'h24 + 32'(r*8), 4'h0, 32'h0));
      start();
      goto(2); chk("t2_drdy", 32'(dmem_ready), 32'd1); chk("t2_irdy_c2", 32'(imem_ready), 32'd0);
               chk("t2_ddata", dmem_in_data, 32'hA500_0009 + 32'(r*2));
      goto(5); chk("t2_irdy", 32'(imem_ready), 32'd1);
               chk("t2_idata", imem_in_data, 32'hA500_0008 + 32'(r*2));
      wait_idle();
    end
    for (int i = 0; i < 3; i++) begin
      iq.push_back(mk(32'(16*i), 4'h0, 32'h0));
      dq.push_back(mk(32'(16*i + 4), 4'h0, 32'h0));
    end
    start();
    wait_idle();

    // Full-word write at the top word, then a half-word write, then read back
    dq.push_back(mk(32'h3FC, 4'hF, 32'hDEAD_BEEF));
    start();
    goto(1); chk("t3_mem_addr", 32'(mem_addr), 32'hFF); chk("t3_mem_rw", 32'(mem_rw), 32'hF);
             chk("t3_mem_wdata", mem_out_data, 32'hDEAD_BEEF);
    goto(2); chk("t3_drdy", 32'(dmem_ready), 32'd1); chk("t3_derr", 32'(dmem_error), 32'd0);
             chk("t3_mem_en_off", 32'(mem_en), 32'd0);
    wait_idle();
    dq.push_back(mk(32'h3F8, 4'b0011, 32'h1234_5678));
    start();
    wait_idle();
    iq.push_back(mk(32'h3FC, 4'h0, 32'h0));
    iq.push_back(mk(32'h3F8, 4'h0, 32'h0));
    start();
    goto(2); chk("t3_rb_full", imem_in_data, 32'hDEAD_BEEF);
    goto(5); chk("t3_rb_half", imem_in_data, 32'hA500_5678);
    wait_idle();

    // Out-of-range requests on both ports
    dq.push_back(mk(32'h400, 4'h0, 32'h0));
    start();
    goto(1); chk("t4_drdy", 32'(dmem_ready), 32'd1); chk("t4_derr", 32'(dmem_error), 32'd1);
             chk("t4_mem_en", 32'(mem_en), 32'd0);
    wait_idle();
    iq.push_back(mk(32'hFFFF_FFF0, 4'hF, 32'h5555_5555));
    start();
    wait_idle();

    // Timeout, then a normal access, then ready on the very last counted cycle
    ws = -1;
    iq.push_back(mk(32'h30, 4'h0, 32'h0));
    start();
    goto(15); chk("t5_mem_en_c15", 32'(mem_en), 32'd1); chk("t5_irdy_c15", 32'(imem_ready), 32'd0);
    goto(16); chk("t5_irdy", 32'(imem_ready), 32'd1); chk("t5_ierr", 32'(imem_error), 32'd1);
              chk("t5_idata", imem_in_data, 32'd0);
    wait_idle();
    ws = 0;
    iq.push_back(mk(32'h30, 4'h0, 32'h0));
    start();
    goto(2); chk("t5_ok_ierr", 32'(imem_error), 32'd0); chk("t5_ok_idata", imem_in_data, 32'hA500_000C);
    wait_idle();
    ws = 14;
    iq.push_back(mk(32'h34, 4'h0, 32'h0));
    start();
    goto(16); chk("t5_edge_irdy", 32'(imem_ready), 32'd1); chk("t5_edge_ierr", 32'(imem_error), 32'd0);
              chk("t5_edge_idata", imem_in_data, 32'hA500_000D);
    wait_idle();

    // Reset during the second BUSY cycle of a data access, then a fresh tie
    ws = 3;
    dq.push_back(mk(32'h40, 4'h0, 32'h0));
    start();
    goto(1); chk("t6_mem_en_c1", 32'(mem_en), 32'd1);
    @(posedge clk); #2; rst = 1; dq.delete(); cur = 2;
    @(posedge clk); #2; rst = 0; cur = 3;
    chk("t6_mem_en_rst", 32'(mem_en), 32'd0); chk("t6_drdy_rst", 32'(dmem_ready), 32'd0);
    chk("t6_derr_rst", 32'(dmem_error), 32'd0);
    repeat (2) @(posedge clk); #6;
    ws = 0;
    iq.push_back(mk(32'h50, 4'h0, 32'h0));
    dq.push_back(mk(32'h54, 4'h0, 32'h0));
    start();
    goto(2); chk("t6_drdy", 32'(dmem_ready), 32'd1); chk("t6_ddata", dmem_in_data, 32'hA500_0015);
    goto(5); chk("t6_irdy", 32'(imem_ready), 32'd1); chk("t6_idata", imem_in_data, 32'hA500_0014);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
